// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode field width, opcode constants and the
// fetch-stage state encoding used by the fetch unit and its debug port.
package isa_pkg;

   localparam int OP_W = 8;

   // Decoder default maps this opcode to all-zero controls.
   localparam logic [OP_W-1:0] NOP_OPCODE = 8'h00;

   // ALU / move group
   localparam logic [OP_W-1:0] OP_ADD     = 8'h80;
   localparam logic [OP_W-1:0] OP_SUB     = 8'h81;
   localparam logic [OP_W-1:0] OP_AND     = 8'h82;
   localparam logic [OP_W-1:0] OP_OR      = 8'h83;
   localparam logic [OP_W-1:0] OP_XOR     = 8'h84;
   localparam logic [OP_W-1:0] OP_NOT     = 8'h85;
   localparam logic [OP_W-1:0] OP_SHIFT   = 8'h86;
   localparam logic [OP_W-1:0] OP_MOVE    = 8'h87;

   // Compare group
   localparam logic [OP_W-1:0] OP_CMP_EQ  = 8'h89;
   localparam logic [OP_W-1:0] OP_CMP_NE  = 8'h8A;
   localparam logic [OP_W-1:0] OP_CMP_LT  = 8'h8B;
   localparam logic [OP_W-1:0] OP_CMP_LE  = 8'h8C;
   localparam logic [OP_W-1:0] OP_CMP_GT  = 8'h8D;
   localparam logic [OP_W-1:0] OP_CMP_GE  = 8'h8E;

   // Memory and control flow
   localparam logic [OP_W-1:0] OP_STORE   = 8'h8F;
   localparam logic [OP_W-1:0] OP_LOAD    = 8'h9F;
   localparam logic [OP_W-1:0] OP_BRANCH  = 8'h90;
   localparam logic [OP_W-1:0] OP_IMED_LD = 8'hA0;
   localparam logic [OP_W-1:0] OP_JUMP    = 8'hB0;

   // Fetch FSM states
   typedef enum logic [1:0] {
      FETCH = 2'd0,   // idle, may launch a request
      WAIT  = 2'd1,   // request outstanding, result wanted
      HOLD  = 2'd2,   // instruction presented to decoder
      DRAIN = 2'd3    // request outstanding, result will be dropped
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// holds the fetched word for the decoder and applies jump/branch redirects.
//
// Handshakes:
//   imem side   - imem_req/imem_addr are held until a one-cycle imem_ack;
//                 imem_rdata is taken in the ack cycle.
//   decoder side - instr/opcode/instr_pc are stable while instr_valid=1 and
//                 instr_ready=0; a transfer happens on instr_valid&&instr_ready.
// A redirect overrides everything; a request already on the bus is always
// completed (acked) before a new one is launched, its data dropped.
module instr_fetch_unit
   import isa_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_en,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [INSTR_W-1:0] instr,
   output logic [OP_W-1:0]    opcode,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               redir_en,
   input  logic [ADDR_W-1:0]  redir_addr,
   output fetch_state_t       dbg_state,
   output logic [ADDR_W-1:0]  dbg_pc
);

   fetch_state_t       state_q;
   logic [ADDR_W-1:0]  pc_q;
   logic [ADDR_W-1:0]  req_addr_q;
   logic               req_q;
   logic               valid_q;
   logic [INSTR_W-1:0] instr_q;
   logic [OP_W-1:0]    opcode_q;
   logic [ADDR_W-1:0]  instr_pc_q;

   // Fetch FSM with PC, request and decoder-facing output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= '0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         instr_q    <= '0;
         opcode_q   <= NOP_OPCODE;
         instr_pc_q <= '0;
      end else begin
         case (state_q)
            FETCH: begin
               if (redir_en) begin
                  pc_q <= redir_addr;
               end else if (fetch_en) begin
                  req_q      <= 1'b1;
                  req_addr_q <= pc_q;
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               if (redir_en) begin
                  pc_q <= redir_addr;
                  if (imem_ack) begin
                     // Data arriving with the redirect is for the wrong path.
                     req_q   <= 1'b0;
                     state_q <= FETCH;
                  end else begin
                     // Request stays on the bus until memory answers.
                     state_q <= DRAIN;
                  end
               end else if (imem_ack) begin
                  instr_q    <= imem_rdata;
                  opcode_q   <= imem_rdata[INSTR_W-1 -: OP_W];
                  instr_pc_q <= req_addr_q;
                  pc_q       <= req_addr_q + 1'b1;
                  valid_q    <= 1'b1;
                  req_q      <= 1'b0;
                  state_q    <= HOLD;
               end
            end
            HOLD: begin
               if (redir_en) begin
                  // A coincident instr_ready is a normal accept; either way
                  // the held word is retired here.
                  valid_q  <= 1'b0;
                  opcode_q <= NOP_OPCODE;
                  pc_q     <= redir_addr;
                  state_q  <= FETCH;
               end else if (instr_ready) begin
                  valid_q  <= 1'b0;
                  opcode_q <= NOP_OPCODE;
                  state_q  <= FETCH;
               end
            end
            DRAIN: begin
               // Latest redirect target wins. An ack arriving in the same
               // cycle still ends the drain, otherwise the FSM would wait
               // for an ack that memory has already given.
               if (redir_en) begin
                  pc_q <= redir_addr;
               end
               if (imem_ack) begin
                  req_q   <= 1'b0;
                  state_q <= FETCH;
               end
            end
            default: begin
               state_q <= FETCH;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = req_addr_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign opcode      = opcode_q;
   assign instr_pc    = instr_pc_q;
   assign dbg_state   = state_q;
   assign dbg_pc      = pc_q;

endmodule
